// File: rtl/alu_cmd_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_cmd_seq_if : command and result valid/ready channels of alu_cmd_seq
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_cmd_seq_if #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [DATA_W-1:0] cmd_A;
   logic [DATA_W-1:0] cmd_B;
   logic [SEL_W-1:0]  cmd_Sel;
   logic              res_valid;
   logic              res_ready;
   logic [DATA_W-1:0] res_Out;
   logic              res_Cout;
   logic [SEL_W-1:0]  res_Sel;

   modport master (
      output cmd_valid, cmd_A, cmd_B, cmd_Sel, res_ready,
      input  cmd_ready, res_valid, res_Out, res_Cout, res_Sel
   );

   modport slave (
      input  cmd_valid, cmd_A, cmd_B, cmd_Sel, res_ready,
      output cmd_ready, res_valid, res_Out, res_Cout, res_Sel
   );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_cmd_seq : flow-controlled issue/collect front-end for alu_8_bit
// Optional result checker enabled by macro ALU_SEQ_CHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module alu_cmd_seq #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3,
   parameter int SETTLE = 1,
   parameter int DEPTH  = 4
) (
   input  wire logic              clk,
   input  wire logic              rst,
   alu_cmd_seq_if.slave           bus,
   output logic [DATA_W-1:0]      A,
   output logic [DATA_W-1:0]      B,
   output logic [SEL_W-1:0]       ALU_Sel,
   input  wire logic [DATA_W-1:0] Out,
   input  wire logic              Cout,
`ifdef ALU_SEQ_CHECK_EN
   output logic                   chk_err,
   output logic [7:0]             chk_cnt,
`endif
   output logic                   busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = SEL_W + 1 + DATA_W;

   localparam logic [1:0]       c_IDLE    = 2'd0;
   localparam logic [1:0]       c_DRIVE   = 2'd1;
   localparam logic [1:0]       c_CAPTURE = 2'd2;
   localparam logic [3:0]       c_SETTLE_LD = 4'(SETTLE - 1);
   localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(DEPTH);

   logic [1:0]       r_state;
   logic [3:0]       r_ctr;
   logic [ENT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_cmd_ready;
   logic             w_accept;
   logic             w_push;
   logic             w_pop;
   logic             w_valid;
   logic [ENT_W-1:0] w_head;

   assign w_cmd_ready = (r_state == c_IDLE) && (r_count < c_DEPTH);
   assign w_accept    = bus.cmd_valid && w_cmd_ready;
   assign w_push      = (r_state == c_CAPTURE);
   assign w_valid     = (r_count != '0);
   assign w_pop       = bus.res_ready && w_valid;
   assign w_head      = r_mem[r_rd_ptr];

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.res_valid = w_valid;
   assign bus.res_Out   = w_valid ? w_head[DATA_W-1:0]      : '0;
   assign bus.res_Cout  = w_valid ? w_head[DATA_W]          : 1'b0;
   assign bus.res_Sel   = w_valid ? w_head[ENT_W-1:DATA_W+1] : '0;
   assign busy          = (r_state != c_IDLE);

   // Operands stay on the ALU inputs until the next accept, not just until capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_IDLE;
         r_ctr   <= '0;
         A       <= '0;
         B       <= '0;
         ALU_Sel <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  A       <= bus.cmd_A;
                  B       <= bus.cmd_B;
                  ALU_Sel <= bus.cmd_Sel;
                  r_ctr   <= c_SETTLE_LD;
                  r_state <= c_DRIVE;
               end
            end
            c_DRIVE: begin
               if (r_ctr == '0) begin
                  r_state <= c_CAPTURE;
               end else begin
                  r_ctr <= r_ctr - 4'd1;
               end
            end
            c_CAPTURE: r_state <= c_IDLE;
            default:   r_state <= c_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {ALU_Sel, Cout, Out};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef ALU_SEQ_CHECK_EN
   logic [DATA_W-1:0] w_expect;
   logic [DATA_W-1:0] w_prod;

   assign w_prod = A * B;

   always_comb begin
      w_expect = '0;
      case (ALU_Sel[2:0])
         3'b000:  w_expect = A + B;
         3'b001:  w_expect = A - B;
         3'b010:  w_expect = A & B;
         3'b011:  w_expect = A | B;
         3'b100:  w_expect = A ^ B;
         3'b101:  w_expect = w_prod;
         3'b110:  w_expect = A >> 1;
         default: w_expect = A << 1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_err <= 1'b0;
         chk_cnt <= '0;
      end else if (w_push && (Out != w_expect)) begin
         chk_err <= 1'b1;
         if (chk_cnt != 8'hFF) begin
            chk_cnt <= chk_cnt + 8'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_cmd_seq : directed + randomized bench for alu_cmd_seq with a
// transaction-level reference model.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_cmd_seq;

   localparam int DATA_W = 8;
   localparam int SEL_W  = 3;
   localparam int SETTLE = 1;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [7:0] o;
      logic       c;
      logic [2:0] s;
   } res_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] A, B, Out;
   logic [2:0] ALU_Sel;
   logic       Cout, busy;
   logic [7:0] fault_mask = 8'h00;
   logic [8:0] w_alu;
`ifdef ALU_SEQ_CHECK_EN
   logic       chk_err;
   logic [7:0] chk_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   alu_cmd_seq_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

   alu_cmd_seq #(.DATA_W(DATA_W), .SEL_W(SEL_W), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .A       (A),
      .B       (B),
      .ALU_Sel (ALU_Sel),
      .Out     (Out),
      .Cout    (Cout),
`ifdef ALU_SEQ_CHECK_EN
      .chk_err (chk_err),
      .chk_cnt (chk_cnt),
`endif
      .busy    (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
      logic [15:0] p;
      p = a * b;
      case (s)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {1'b0, p[7:0]};
         3'd6:    return {1'b0, a >> 1};
         default: return {1'b0, a << 1};
      endcase
   endfunction

   // Combinational ALU stand-in; fault_mask lets the bench corrupt one capture.
   assign w_alu = alu_ref(A, B, ALU_Sel);
   assign Out   = w_alu[7:0] ^ fault_mask;
   assign Cout  = w_alu[8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   res_t       m_q[$];
   logic       m_busy;
   logic [7:0] m_a, m_b;
   logic [2:0] m_s;
   int         m_edge, m_done;
   logic       m_acc;
   logic [8:0] m_r;
   res_t       m_ent;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_busy = 1'b0;
         m_a = '0; m_b = '0; m_s = '0;
         m_edge = 0;
         m_done = 0;
      end else begin
         m_acc = bus.cmd_valid && !m_busy && (m_q.size() < DEPTH);
         if (bus.res_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (m_busy && m_edge == m_done) begin
            m_r     = alu_ref(m_a, m_b, m_s);
            m_ent.o = m_r[7:0] ^ fault_mask;
            m_ent.c = m_r[8];
            m_ent.s = m_s;
            m_q.push_back(m_ent);
            m_busy = 1'b0;
         end
         if (m_acc) begin
            m_a = bus.cmd_A; m_b = bus.cmd_B; m_s = bus.cmd_Sel;
            m_done = m_edge + SETTLE + 1;
            m_busy = 1'b1;
         end
         m_edge++;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cmd_ready", bus.cmd_ready, (!m_busy && m_q.size() < DEPTH));
         chk("busy", busy, m_busy);
         chk("A", A, m_a);
         chk("B", B, m_b);
         chk("ALU_Sel", ALU_Sel, m_s);
         chk("res_valid", bus.res_valid, (m_q.size() > 0));
         if (m_q.size() > 0) begin
            chk("res_Out", bus.res_Out, m_q[0].o);
            chk("res_Cout", bus.res_Cout, m_q[0].c);
            chk("res_Sel", bus.res_Sel, m_q[0].s);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      int t = 0;
      while (!bus.cmd_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("issue_ready_timeout", bus.cmd_ready, 1);
      bus.cmd_A = a; bus.cmd_B = b; bus.cmd_Sel = s;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic pop_chk(input string nm, input logic [7:0] exp);
      int t = 0;
      while (!bus.res_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_valid"}, bus.res_valid, 1);
      chk(nm, bus.res_Out, exp);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", busy, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bus.cmd_valid = 1'b0; bus.cmd_A = '0; bus.cmd_B = '0; bus.cmd_Sel = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_Sel", ALU_Sel, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      chk("rst_res_Out", bus.res_Out, 0);
      chk("rst_res_Cout", bus.res_Cout, 0);
      chk("rst_res_Sel", bus.res_Sel, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single add: latency from accept edge to first valid
      issue(8'h0C, 8'h05, 3'b000);
      lat = 0;
      while (!bus.res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk("add_latency", lat, SETTLE + 1);
      chk("add_Out", bus.res_Out, 8'h11);
      chk("add_Sel", bus.res_Sel, 3'b000);
      pop_chk("add_pop", 8'h11);

      // Back-to-back sub/and/mul, ready low while in flight
      issue(8'h0C, 8'h05, 3'b001);
      chk("b2b_ready_drive", bus.cmd_ready, 0);
      chk("b2b_busy_drive", busy, 1);
      issue(8'hCC, 8'hAA, 3'b010);
      issue(8'h0C, 8'h05, 3'b101);
      pop_chk("b2b_sub", 8'h07);
      pop_chk("b2b_and", 8'h88);
      pop_chk("b2b_mul", 8'h3C);

      // Backpressure: fill FIFO, fifth command must wait for a pop
      issue(8'h01, 8'h02, 3'b000);
      issue(8'h10, 8'h01, 3'b001);
      issue(8'hF0, 8'h0F, 3'b011);
      issue(8'h55, 8'hFF, 3'b100);
      wait_idle();
      bus.cmd_A = 8'h21; bus.cmd_B = 8'h03; bus.cmd_Sel = 3'b000;
      bus.cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("bp_full_ready", bus.cmd_ready, 0);
      chk("bp_head", bus.res_Out, 8'h03);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("bp_ready_after_pop", bus.cmd_ready, 1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      pop_chk("bp_r2", 8'h0F);
      pop_chk("bp_r3", 8'hFF);
      pop_chk("bp_r4", 8'hAA);
      pop_chk("bp_r5", 8'h24);

      // Push and pop on the same edge
      issue(8'h03, 8'h04, 3'b000);
      lat = 0;
      while (!bus.res_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      issue(8'h02, 8'h03, 3'b101);
      repeat (SETTLE) @(negedge clk);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("pp_valid", bus.res_valid, 1);
      chk("pp_head", bus.res_Out, 8'h06);
      pop_chk("pp_pop", 8'h06);
      chk("pp_empty", bus.res_valid, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bus.cmd_valid = ($urandom_range(0, 2) != 0);
         bus.cmd_A     = 8'($urandom);
         bus.cmd_B     = 8'($urandom);
         bus.cmd_Sel   = 3'($urandom);
         bus.res_ready = (i % 512 < 256) ? ($urandom_range(0, 3) == 0)
                                         : ($urandom_range(0, 3) != 0);
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      repeat (20) @(negedge clk);
      bus.res_ready = 1'b0;

      // Reset in the middle of DRIVE with a result waiting
      issue(8'h11, 8'h22, 3'b000);
      wait_idle();
      issue(8'h33, 8'h01, 3'b001);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_A", A, 0);
      chk("mid_rst_B", B, 0);
      chk("mid_rst_Sel", ALU_Sel, 0);
      chk("mid_rst_valid", bus.res_valid, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_valid", bus.res_valid, 0);
      chk("post_rst_busy", busy, 0);

`ifdef ALU_SEQ_CHECK_EN
      issue(8'h0C, 8'h0C, 3'b110);
      pop_chk("chk_shr", 8'h06);
      issue(8'h0C, 8'h0C, 3'b111);
      pop_chk("chk_shl", 8'h18);
      chk("chk_err_clean", chk_err, 0);
      fault_mask = 8'h01;
      issue(8'h0C, 8'h05, 3'b000);
      wait_idle();
      fault_mask = 8'h00;
      chk("chk_err_set", chk_err, 1);
      chk("chk_cnt_one", chk_cnt, 1);
      pop_chk("chk_bad", 8'h10);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
